// File: rtl/alu_pkg.sv
// Shared types for the clocked ALU: opcode encoding, flag bit positions
// and controller states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_NOT  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_INC  = 4'd4,
      OP_DEC  = 4'd5,
      OP_AND  = 4'd6,
      OP_OR   = 4'd7,
      OP_XOR  = 4'd8,
      OP_SHR  = 4'd9,
      OP_SHL  = 4'd10,
      OP_MUL  = 4'd11
   } alu_op_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_SHR) || (op == OP_SHL) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifter and shift-add multiplier.
// Loaded on start; last is high during the cycle of the final step.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res,
   output logic             cout
);

   localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);

   logic [SHW-1:0]     k_c;
   logic [SHW-1:0]     cnt_p0;
   alu_op_t            mode_p0;
   logic [WIDTH-1:0]   shreg_p0;
   logic               cout_p0;
   logic [2*WIDTH-1:0] acc_p0;
   logic [2*WIDTH-1:0] mcand_p0;
   logic [WIDTH-1:0]   mplier_p0;

   assign k_c = (b > WMAX) ? SHW'(WIDTH) : b[SHW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0 <= '0;
      end else if (start) begin
         cnt_p0 <= (op == OP_MUL) ? SHW'(WIDTH) : k_c;
      end else if (cnt_p0 != '0) begin
         cnt_p0 <= cnt_p0 - SHW'(1);
      end
   end

   // Stage p0: working registers, stepped once per cycle while cnt_p0 != 0
   always_ff @(posedge clk) begin
      if (start) begin
         mode_p0   <= alu_op_t'(op);
         shreg_p0  <= a;
         cout_p0   <= 1'b0;
         acc_p0    <= '0;
         mcand_p0  <= {{WIDTH{1'b0}}, a};
         mplier_p0 <= b;
      end else if (cnt_p0 != '0) begin
         case (mode_p0)
            OP_SHL: begin
               cout_p0  <= shreg_p0[WIDTH-1];
               shreg_p0 <= shreg_p0 << 1;
            end
            OP_SHR: begin
               cout_p0  <= shreg_p0[0];
               shreg_p0 <= shreg_p0 >> 1;
            end
            default: begin
               if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
               mcand_p0  <= mcand_p0 << 1;
               mplier_p0 <= mplier_p0 >> 1;
            end
         endcase
      end
   end

   assign last = (cnt_p0 == SHW'(1));
   assign res  = (mode_p0 == OP_MUL) ? acc_p0[WIDTH-1:0] : shreg_p0;
   assign cout = (mode_p0 == OP_MUL) ? (|acc_p0[2*WIDTH-1:WIDTH]) : cout_p0;

endmodule

// File: rtl/alu_core.sv
// Registered ALU with valid/ready on both sides: FSM, single-cycle ops,
// flag generation and output registers; iterative ops in alu_iter_unit.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_err
);

   state_t           state_p0;
   state_t           state_nx;
   logic             accept;
   logic             iter_start;
   logic             iter_last;
   logic [WIDTH-1:0] iter_res;
   logic             iter_cout;

   alu_op_t          op_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;

   logic [WIDTH-1:0] res_c;
   logic [WIDTH-1:0] opnd_c;
   logic [WIDTH:0]   sum_c;
   logic             c_c;
   logic             v_c;
   logic             err_c;
   logic [3:0]       flags_c;

   assign in_ready   = (state_p0 == IDLE);
   assign accept     = in_valid && in_ready;
   assign iter_start = accept && is_iter_op(in_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_p0 <= IDLE;
      else        state_p0 <= state_nx;
   end

   always_comb begin
      state_nx = state_p0;
      case (state_p0)
         IDLE: begin
            if (accept) begin
               if ((in_op == OP_MUL) ||
                   (((in_op == OP_SHL) || (in_op == OP_SHR)) && (in_b != '0)))
                  state_nx = BUSY;
               else
                  state_nx = DONE;
            end
         end
         BUSY:    if (iter_last) state_nx = DONE;
         DONE:    if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Stage p0: operand and opcode capture at accept
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= alu_op_t'(in_op);
         a_p0  <= in_a;
         b_p0  <= in_b;
      end
   end

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (iter_start),
      .op    (in_op),
      .a     (in_a),
      .b     (in_b),
      .last  (iter_last),
      .res   (iter_res),
      .cout  (iter_cout)
   );

   // Borrow falls out as bit WIDTH of the zero-extended difference.
   always_comb begin
      res_c  = '0;
      opnd_c = '0;
      sum_c  = '0;
      c_c    = 1'b0;
      v_c    = 1'b0;
      err_c  = 1'b0;
      case (op_p0)
         OP_PASS: res_c = a_p0;
         OP_NOT:  res_c = ~a_p0;
         OP_ADD, OP_INC: begin
            opnd_c = (op_p0 == OP_INC) ? WIDTH'(1) : b_p0;
            sum_c  = {1'b0, a_p0} + {1'b0, opnd_c};
            res_c  = sum_c[WIDTH-1:0];
            c_c    = sum_c[WIDTH];
            v_c    = (a_p0[WIDTH-1] == opnd_c[WIDTH-1]) &&
                     (res_c[WIDTH-1] != a_p0[WIDTH-1]);
         end
         OP_SUB, OP_DEC: begin
            opnd_c = (op_p0 == OP_DEC) ? WIDTH'(1) : b_p0;
            sum_c  = {1'b0, a_p0} - {1'b0, opnd_c};
            res_c  = sum_c[WIDTH-1:0];
            c_c    = sum_c[WIDTH];
            v_c    = (a_p0[WIDTH-1] != opnd_c[WIDTH-1]) &&
                     (res_c[WIDTH-1] != a_p0[WIDTH-1]);
         end
         OP_AND: res_c = a_p0 & b_p0;
         OP_OR:  res_c = a_p0 | b_p0;
         OP_XOR: res_c = a_p0 ^ b_p0;
         OP_SHR, OP_SHL: begin
            res_c = iter_res;
            c_c   = iter_cout;
         end
         OP_MUL: begin
            res_c = iter_res;
            c_c   = iter_cout;
            v_c   = iter_cout;
         end
         default: err_c = 1'b1;
      endcase

      flags_c         = '0;
      flags_c[FLAG_Z] = (res_c == '0);
      flags_c[FLAG_N] = res_c[WIDTH-1];
      flags_c[FLAG_C] = c_c;
      flags_c[FLAG_V] = v_c;
      if (err_c) flags_c = '0;
   end

   // Stage p1: output registers, loaded once on entry to DONE, held until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         out_err    <= 1'b0;
      end else if ((state_p0 == DONE) && !out_valid) begin
         out_valid  <= 1'b1;
         out_result <= res_c;
         out_flags  <= flags_c;
         out_err    <= err_c;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: latency, results, flags, backpressure,
// reset during an iterative op and undefined opcodes.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_flags;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   alu_core #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one op and returns the number of edges after the accept edge
   // until out_valid is seen (-1 on timeout); inputs are scrambled after accept.
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic saw_rdy);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 4'h2; in_a = 16'hA5A5; in_b = 16'h5A5A;
      lat = -1;
      saw_rdy = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         if (out_valid) begin
            lat = i;
            break;
         end
         if (in_ready) saw_rdy = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++;
      if (out_result !== 16'h0 || out_flags !== 4'h0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got %h/%b/%b exp 0000/0000/0", out_result, out_flags, out_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_arith();
      logic [3:0]  ops  [5] = '{OP_ADD,   OP_SUB,   OP_DEC,   OP_INC,   OP_AND};
      logic [15:0] va   [5] = '{16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hF0F0};
      logic [15:0] vb   [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0FF0};
      logic [15:0] eres [5] = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h00F0};
      logic [3:0]  eflg [5] = '{4'b0101,  4'b1000,  4'b0110,  4'b1010,  4'b0000};
      int lat;
      logic sr;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], va[i], vb[i], lat, sr);
         checks++;
         if (lat !== 1) begin errors++; $display("FAIL arith%0d_latency got %0d exp 1", i, lat); end
         checks++;
         if (out_result !== eres[i]) begin errors++; $display("FAIL arith%0d_result got %h exp %h", i, out_result, eres[i]); end
         checks++;
         if (out_flags !== eflg[i]) begin errors++; $display("FAIL arith%0d_flags got %b exp %b", i, out_flags, eflg[i]); end
         checks++;
         if (out_err !== 1'b0) begin errors++; $display("FAIL arith%0d_err got %b exp 0", i, out_err); end
         consume();
      end
   endtask

   task automatic test_shift();
      logic [3:0]  ops  [3] = '{OP_SHL,   OP_SHL,   OP_SHR};
      logic [15:0] va   [3] = '{16'h0001, 16'h0001, 16'h8001};
      logic [15:0] vb   [3] = '{16'd4,    16'd20,   16'd0};
      logic [15:0] eres [3] = '{16'h0010, 16'h0000, 16'h8001};
      logic [3:0]  eflg [3] = '{4'b0000,  4'b0101,  4'b0010};
      int          elat [3] = '{5,        17,       1};
      int lat;
      logic sr;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], va[i], vb[i], lat, sr);
         checks++;
         if (lat !== elat[i]) begin errors++; $display("FAIL shift%0d_latency got %0d exp %0d", i, lat, elat[i]); end
         checks++;
         if (out_result !== eres[i]) begin errors++; $display("FAIL shift%0d_result got %h exp %h", i, out_result, eres[i]); end
         checks++;
         if (out_flags !== eflg[i]) begin errors++; $display("FAIL shift%0d_flags got %b exp %b", i, out_flags, eflg[i]); end
         consume();
      end
   endtask

   task automatic test_mul();
      logic [15:0] va   [2] = '{16'h0003, 16'h0100};
      logic [15:0] vb   [2] = '{16'h0005, 16'h0100};
      logic [15:0] eres [2] = '{16'h000F, 16'h0000};
      logic [3:0]  eflg [2] = '{4'b0000,  4'b1101};
      int lat;
      logic sr;
      for (int i = 0; i < 2; i++) begin
         run_op(OP_MUL, va[i], vb[i], lat, sr);
         checks++;
         if (lat !== 17) begin errors++; $display("FAIL mul%0d_latency got %0d exp 17", i, lat); end
         checks++;
         if (sr !== 1'b0) begin errors++; $display("FAIL mul%0d_ready_while_busy got %b exp 0", i, sr); end
         checks++;
         if (out_result !== eres[i]) begin errors++; $display("FAIL mul%0d_result got %h exp %h", i, out_result, eres[i]); end
         checks++;
         if (out_flags !== eflg[i]) begin errors++; $display("FAIL mul%0d_flags got %b exp %b", i, out_flags, eflg[i]); end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic sr;
      run_op(OP_XOR, 16'hF0F0, 16'h0FF0, lat, sr);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp%0d_hold valid/ready got %b/%b exp 1/0", i, out_valid, in_ready);
         end
         checks++;
         if (out_result !== 16'hFF00 || out_flags !== 4'b0010) begin
            errors++;
            $display("FAIL bp%0d_data got %h/%b exp ff00/0010", i, out_result, out_flags);
         end
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release ready/valid got %b/%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_busy();
      int lat;
      logic sr;
      in_op = OP_MUL; in_a = 16'h1234; in_b = 16'h0042; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_busy valid/ready got %b/%b exp 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_discard got %b exp 0", out_valid); end
      run_op(OP_ADD, 16'd2, 16'd3, lat, sr);
      checks++;
      if (lat !== 1 || out_result !== 16'h0005) begin
         errors++;
         $display("FAIL rst_busy_add lat/result got %0d/%h exp 1/0005", lat, out_result);
      end
      consume();
   endtask

   task automatic test_undef();
      int lat;
      logic sr;
      run_op(4'hF, 16'hFFFF, 16'h1234, lat, sr);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL undef_latency got %0d exp 1", lat); end
      checks++;
      if (out_err !== 1'b1 || out_result !== 16'h0 || out_flags !== 4'h0) begin
         errors++;
         $display("FAIL undef_out got %b/%h/%b exp 1/0000/0000", out_err, out_result, out_flags);
      end
      consume();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_a = '0; in_b = '0; out_ready = 1'b0;
      test_reset();
      test_arith();
      test_shift();
      test_mul();
      test_backpressure();
      test_reset_busy();
      test_undef();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
